// File: rtl/functional_unit_if.sv
// Issue and result bus between a reservation station / CDB arbiter and one functional unit.
// The unit takes the slave modport; the issuing side takes the master modport.
interface functional_unit_if;
  logic        new_instruction;
  logic [2:0]  instruction_tag;
  logic [31:0] a;
  logic [31:0] b;
  logic        functional_unit_ready;
  logic        fu_valid;
  logic [2:0]  fu_tag;
  logic [31:0] fu_value;
  logic        cdb_grant;
  logic [3:0]  occupancy;
  logic        tag_error;

  modport master (
    output new_instruction, instruction_tag, a, b, cdb_grant,
    input  functional_unit_ready, fu_valid, fu_tag, fu_value, occupancy, tag_error
  );

  modport slave (
    input  new_instruction, instruction_tag, a, b, cdb_grant,
    output functional_unit_ready, fu_valid, fu_tag, fu_value, occupancy, tag_error
  );
endinterface

// File: rtl/functional_unit.sv
// Pipelined add or multiply unit feeding a 2-entry result buffer that drains onto the CDB.
// The pipeline stalls only when its last stage holds a result and the buffer cannot take it.
module functional_unit #(
  parameter int ADD_OR_MUL = 0,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  functional_unit_if.slave bus
);

  localparam int DATA_W   = 32;
  localparam bit UNIT_BIT = (ADD_OR_MUL != 0);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [2:0]         tag_q [LATENCY];
  logic [DATA_W-1:0]  res_q [LATENCY];

  logic [2:0]         fifo_tag_q [2];
  logic [DATA_W-1:0]  fifo_val_q [2];
  logic               wptr_q, wptr_d;
  logic               rptr_q, rptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [3:0]         occ_q, occ_d;
  logic               err_q, err_d;

  logic pop, push, advance, issue, accept, unit_ok, last_vld;

  // Only the low DATA_W bits are kept, so signedness of the operands does not matter.
  function automatic logic [DATA_W-1:0] compute(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    if (UNIT_BIT) return x * y;
    else          return x + y;
  endfunction

  always_comb begin
    last_vld = vld_q[LATENCY-1];
    unit_ok  = (bus.instruction_tag[2] == UNIT_BIT);
    pop      = (cnt_q != 2'd0) && bus.cdb_grant;
    advance  = !(last_vld && (cnt_q == 2'd2) && !pop);
    issue    = bus.new_instruction && advance;
    accept   = issue && unit_ok;
    push     = advance && last_vld;
  end

  always_comb begin
    vld_d = vld_q;
    if (advance) begin
      vld_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) vld_d[i] = vld_q[i-1];
    end
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ pop;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    // A push only moves a result from the pipe into the buffer, so it leaves occupancy unchanged.
    occ_d  = occ_q + {3'b000, accept} - {3'b000, pop};
    err_d  = err_q | (issue && !unit_ok);
  end

  // ---- control state: stage valids, buffer pointers, counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
      occ_q  <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      occ_q  <= occ_d;
      err_q  <= err_d;
    end
  end

  // ---- datapath: stage payloads and buffer entries, qualified by the valids above ----
  always_ff @(posedge clk) begin
    if (advance) begin
      tag_q[0] <= bus.instruction_tag;
      res_q[0] <= compute(bus.a, bus.b);
      for (int i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
        res_q[i] <= res_q[i-1];
      end
    end
    if (push) begin
      fifo_tag_q[wptr_q] <= tag_q[LATENCY-1];
      fifo_val_q[wptr_q] <= res_q[LATENCY-1];
    end
  end

  // ---- outputs: buffer head is masked to zero while empty ----
  always_comb begin
    bus.functional_unit_ready = advance;
    bus.fu_valid              = (cnt_q != 2'd0);
    bus.fu_tag                = bus.fu_valid ? fifo_tag_q[rptr_q] : 3'd0;
    bus.fu_value              = bus.fu_valid ? fifo_val_q[rptr_q] : '0;
    bus.occupancy             = occ_q;
    bus.tag_error             = err_q;
  end

endmodule

// File: tb/tb_functional_unit.sv
// Bench for functional_unit: an adder (LATENCY=2) checked against a queue-based reference
// model every cycle, plus a multiplier (LATENCY=3) exercised with directed operand pairs.
module tb_functional_unit;

  localparam int AL = 2;
  localparam int ML = 3;

  typedef struct packed {
    logic        v;
    logic [2:0]  t;
    logic [31:0] d;
  } item_t;

  logic clk;
  logic rst_n;

  functional_unit_if abus ();
  functional_unit_if mbus ();

  functional_unit #(.ADD_OR_MUL(0), .LATENCY(AL)) u_add (.clk(clk), .rst_n(rst_n), .bus(abus.slave));
  functional_unit #(.ADD_OR_MUL(1), .LATENCY(ML)) u_mul (.clk(clk), .rst_n(rst_n), .bus(mbus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  item_t pipe[$];
  item_t fq[$];
  bit    err_m;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    item_t bub;
    bub = '0;
    pipe.delete();
    fq.delete();
    for (int i = 0; i < AL; i++) pipe.push_back(bub);
    err_m = 1'b0;
  endtask

  task automatic drive(input logic ni, input logic [2:0] tg, input logic [31:0] av,
                       input logic [31:0] bv, input logic gr);
    abus.new_instruction = ni;
    abus.instruction_tag = tg;
    abus.a               = av;
    abus.b               = bv;
    abus.cdb_grant       = gr;
    #1;
  endtask

  task automatic mdrive(input logic ni, input logic [2:0] tg, input logic [31:0] av,
                        input logic [31:0] bv, input logic gr);
    mbus.new_instruction = ni;
    mbus.instruction_tag = tg;
    mbus.a               = av;
    mbus.b               = bv;
    mbus.cdb_grant       = gr;
  endtask

  // Compare the adder against the model, then let one clock edge pass and update the model.
  task automatic tick();
    item_t       nw, last;
    bit          popm, adv;
    int          occm;
    logic        ni, gr;
    logic [2:0]  tg;
    logic [31:0] av, bv;
    ni = abus.new_instruction; tg = abus.instruction_tag;
    av = abus.a; bv = abus.b; gr = abus.cdb_grant;
    popm = (fq.size() > 0) && gr;
    adv  = !(pipe[AL-1].v && (fq.size() == 2) && !popm);
    occm = fq.size();
    foreach (pipe[i]) if (pipe[i].v) occm++;
    chk("add_ready", {31'd0, abus.functional_unit_ready}, {31'd0, adv});
    chk("add_valid", {31'd0, abus.fu_valid}, (fq.size() > 0) ? 32'd1 : 32'd0);
    chk("add_tag", {29'd0, abus.fu_tag}, (fq.size() > 0) ? {29'd0, fq[0].t} : 32'd0);
    chk("add_value", abus.fu_value, (fq.size() > 0) ? fq[0].d : 32'd0);
    chk("add_occupancy", {28'd0, abus.occupancy}, occm);
    chk("add_tag_error", {31'd0, abus.tag_error}, {31'd0, err_m});
    @(posedge clk);
    if (popm) void'(fq.pop_front());
    if (ni && adv && tg[2]) err_m = 1'b1;
    if (adv) begin
      last = pipe.pop_back();
      if (last.v) fq.push_back(last);
      nw.v = ni && !tg[2];
      nw.t = tg;
      nw.d = av + bv;
      pipe.push_front(nw);
    end
    @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_add_valid"}, {31'd0, abus.fu_valid}, 32'd0);
    chk({pfx, "_add_tag"}, {29'd0, abus.fu_tag}, 32'd0);
    chk({pfx, "_add_value"}, abus.fu_value, 32'd0);
    chk({pfx, "_add_occ"}, {28'd0, abus.occupancy}, 32'd0);
    chk({pfx, "_add_err"}, {31'd0, abus.tag_error}, 32'd0);
    chk({pfx, "_add_ready"}, {31'd0, abus.functional_unit_ready}, 32'd1);
    chk({pfx, "_mul_valid"}, {31'd0, mbus.fu_valid}, 32'd0);
    chk({pfx, "_mul_value"}, mbus.fu_value, 32'd0);
    chk({pfx, "_mul_occ"}, {28'd0, mbus.occupancy}, 32'd0);
    chk({pfx, "_mul_ready"}, {31'd0, mbus.functional_unit_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rt;
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    mdrive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Add latency: result appears after edge 2 and is taken at edge 3.
    drive(1'b1, 3'b001, 32'd5, 32'd7, 1'b1); tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1); tick();
    chk("lat_e1_valid", {31'd0, abus.fu_valid}, 32'd0);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1); tick();
    chk("lat_e2_valid", {31'd0, abus.fu_valid}, 32'd1);
    chk("lat_e2_tag", {29'd0, abus.fu_tag}, 32'd1);
    chk("lat_e2_value", abus.fu_value, 32'd12);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1); tick();
    chk("lat_e3_valid", {31'd0, abus.fu_valid}, 32'd0);

    // Multiplier wrap-around with two back-to-back issues.
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    mdrive(1'b1, 3'b110, 32'h0001_0000, 32'h0001_0000, 1'b1); tick();
    mdrive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd2, 1'b1); tick();
    mdrive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    chk("mul_occ2", {28'd0, mbus.occupancy}, 32'd2);
    tick();
    chk("mul_e2_valid", {31'd0, mbus.fu_valid}, 32'd0);
    tick();
    chk("mul_e3_valid", {31'd0, mbus.fu_valid}, 32'd1);
    chk("mul_e3_tag", {29'd0, mbus.fu_tag}, 32'd6);
    chk("mul_e3_value", mbus.fu_value, 32'h0000_0000);
    tick();
    chk("mul_e4_valid", {31'd0, mbus.fu_valid}, 32'd1);
    chk("mul_e4_value", mbus.fu_value, 32'hFFFF_FFFE);
    tick();
    chk("mul_e5_valid", {31'd0, mbus.fu_valid}, 32'd0);
    mdrive(1'b1, 3'b010, 32'd3, 32'd3, 1'b1);
    chk("mul_tag_ok_ready", {31'd0, mbus.functional_unit_ready}, 32'd1);
    tick();
    mdrive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    chk("mul_wrong_unit_err", {31'd0, mbus.tag_error}, 32'd1);
    chk("mul_wrong_unit_occ", {28'd0, mbus.occupancy}, 32'd0);

    // Back-pressure: four issues fill pipe and buffer, then the unit refuses more.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i), $urandom, $urandom, 1'b0); tick();
    end
    drive(1'b1, 3'b000, 32'd9, 32'd9, 1'b0);
    chk("bp_ready", {31'd0, abus.functional_unit_ready}, 32'd0);
    chk("bp_occ", {28'd0, abus.occupancy}, 32'd4);
    tick(); tick();
    chk("bp_occ_held", {28'd0, abus.occupancy}, 32'd4);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    chk("full_pop_push_ready", {31'd0, abus.functional_unit_ready}, 32'd1);
    chk("drain_tag0", {29'd0, abus.fu_tag}, 32'd0);
    tick();
    chk("full_pop_push_valid", {31'd0, abus.fu_valid}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk("drain_tag", {29'd0, abus.fu_tag}, i);
      tick();
    end
    chk("drain_empty", {31'd0, abus.fu_valid}, 32'd0);

    // Wrong unit tag: flagged, nothing enters the pipe.
    drive(1'b1, 3'b100, 32'd1, 32'd1, 1'b1); tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    chk("mismatch_err", {31'd0, abus.tag_error}, 32'd1);
    chk("mismatch_occ", {28'd0, abus.occupancy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mismatch_no_valid", {31'd0, abus.fu_valid}, 32'd0);
    end

    // Reset in the middle of operation with two results in flight.
    drive(1'b1, 3'b001, 32'd10, 32'd20, 1'b0); tick();
    drive(1'b1, 3'b010, 32'd30, 32'd40, 1'b0); tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1); tick();
      chk("post_reset_no_valid", {31'd0, abus.fu_valid}, 32'd0);
    end

    // Randomised traffic with bursty grants against the reference model.
    for (int n = 0; n < 400; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
      rt = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) rt[2] = 1'b1;
      drive(($urandom_range(0, 9) < 6), rt, ra, rb,
            (n % 64 < 24) ? 1'b0 : 1'($urandom_range(0, 1)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
